// File: rtl/elixirchip_es1_spu_pkg.sv
// rtl/elixirchip_es1_spu_pkg.sv - shared types and helpers for SPU operators
package elixirchip_es1_spu_pkg;

    // Per-beat accumulator opcode
    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_HOLD = 2'd3
    } op_t;

    // Largest value representable in a two's complement field of the given width
    function automatic longint signed_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a two's complement field of the given width
    function automatic longint signed_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_delay_an.sv
// rtl/elixirchip_es1_spu_delay_an.sv - cke-gated delay line with async active-low reset
module elixirchip_es1_spu_delay_an #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cke,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Zero depth degenerates to a plain wire; the control inputs are intentionally idle
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, reset_n, cke};
            assign dout = din;
        end else begin : g_reg
            logic [WIDTH-1:0] stage [DEPTH];

            // Shift the whole line one step on every enabled cycle
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else if (cke) begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/elixirchip_es1_spu_op_mac.sv
// rtl/elixirchip_es1_spu_op_mac.sv - pipelined multiply-accumulate SPU operator
module elixirchip_es1_spu_op_mac
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int                     LATENCY      = 4,
    parameter int                     S_DATA0_BITS = 8,
    parameter int                     S_DATA1_BITS = 8,
    parameter bit                     DATA0_SIGNED = 1'b1,
    parameter bit                     DATA1_SIGNED = 1'b0,
    parameter int                     ACC_BITS     = S_DATA0_BITS + S_DATA1_BITS + 8,
    parameter int                     M_DATA_BITS  = 16,
    parameter int                     DATA_SHIFT   = 0,
    parameter bit                     ROUND        = 1'b0,
    parameter bit                     SATURATE     = 1'b0,
    parameter logic [M_DATA_BITS-1:0] CLEAR_DATA   = '0,
    parameter                         DEVICE       = "RTL",
    parameter                         SIMULATION   = "false",
    parameter                         DEBUG        = "false"
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cke,
    input  logic [S_DATA0_BITS-1:0] s_data0,
    input  logic [S_DATA1_BITS-1:0] s_data1,
    input  logic [1:0]              s_op,
    input  logic                    s_clear,
    input  logic                    s_valid,
    output logic [M_DATA_BITS-1:0]  m_data,
    output logic                    m_sat,
    output logic                    m_valid
);

    // Product width: wide enough that unsigned x unsigned still fits as a signed value
    localparam int PW = S_DATA0_BITS + S_DATA1_BITS + 1;
    // Output arithmetic width: one guard bit over the accumulator so rounding never
    // overflows, and never narrower than the output so truncation sign-extends
    localparam int RW = (ACC_BITS + 1 > M_DATA_BITS) ? ACC_BITS + 1 : M_DATA_BITS;
    localparam int RND_POS = (DATA_SHIFT > 0) ? DATA_SHIFT - 1 : 0;
    localparam logic signed [RW-1:0] R_RND = (ROUND && DATA_SHIFT > 0) ? (RW'(1) << RND_POS) : '0;
    localparam logic signed [RW-1:0] R_MAX = RW'(signed_max(M_DATA_BITS));
    localparam logic signed [RW-1:0] R_MIN = RW'(signed_min(M_DATA_BITS));
    localparam int TAIL = (LATENCY > 4) ? LATENCY - 4 : 0;

    generate
        if (LATENCY < 4) begin : g_bad_latency
            $error("elixirchip_es1_spu_op_mac: LATENCY must be at least 4");
        end
        if (ACC_BITS < PW) begin : g_bad_acc
            $error("elixirchip_es1_spu_op_mac: ACC_BITS must be at least S_DATA0_BITS+S_DATA1_BITS+1");
        end
        if (DATA_SHIFT < 0 || DATA_SHIFT >= ACC_BITS) begin : g_bad_shift
            $error("elixirchip_es1_spu_op_mac: DATA_SHIFT must be in 0..ACC_BITS-1");
        end
        if (DEVICE == "") begin : g_bad_device
            $error("elixirchip_es1_spu_op_mac: DEVICE must not be empty");
        end
        if (SIMULATION != "true" && SIMULATION != "false") begin : g_bad_sim
            $error("elixirchip_es1_spu_op_mac: SIMULATION must be \"true\" or \"false\"");
        end
        if (DEBUG != "true" && DEBUG != "false") begin : g_bad_debug
            $error("elixirchip_es1_spu_op_mac: DEBUG must be \"true\" or \"false\"");
        end
    endgenerate

    // ---------------------------------------------------------------- stage 0
    logic [S_DATA0_BITS-1:0] s0_data0;
    logic [S_DATA1_BITS-1:0] s0_data1;
    op_t                     s0_op;
    logic                    s0_clear;
    logic                    s0_valid;

    // Capture the input beat as-is
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_data0 <= '0;
            s0_data1 <= '0;
            s0_op    <= OP_LOAD;
            s0_clear <= 1'b0;
            s0_valid <= 1'b0;
        end else if (cke) begin
            s0_data0 <= s_data0;
            s0_data1 <= s_data1;
            s0_op    <= op_t'(s_op);
            s0_clear <= s_clear;
            s0_valid <= s_valid;
        end
    end

    // ---------------------------------------------------------------- stage 1
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] p_comb;

    generate
        if (DATA0_SIGNED) begin : g_a_signed
            assign a_ext = PW'($signed(s0_data0));
        end else begin : g_a_unsigned
            assign a_ext = PW'(s0_data0);
        end
        if (DATA1_SIGNED) begin : g_b_signed
            assign b_ext = PW'($signed(s0_data1));
        end else begin : g_b_unsigned
            assign b_ext = PW'(s0_data1);
        end
    endgenerate

    assign p_comb = a_ext * b_ext;

    logic signed [PW-1:0] s1_p;
    op_t                  s1_op;
    logic                 s1_clear;
    logic                 s1_valid;

    // Register the exact product alongside the beat controls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_p     <= '0;
            s1_op    <= OP_LOAD;
            s1_clear <= 1'b0;
            s1_valid <= 1'b0;
        end else if (cke) begin
            s1_p     <= p_comb;
            s1_op    <= s0_op;
            s1_clear <= s0_clear;
            s1_valid <= s0_valid;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic signed [ACC_BITS-1:0] p_acc;
    logic signed [ACC_BITS-1:0] acc;
    logic                       s2_clear;
    logic                       s2_valid;

    assign p_acc = ACC_BITS'(s1_p);

    // Single-cycle accumulator feedback so consecutive ADD beats need no bubbles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            s2_clear <= 1'b0;
            s2_valid <= 1'b0;
        end else if (cke) begin
            s2_clear <= s1_clear;
            s2_valid <= s1_valid;
            if (s1_valid) begin
                if (s1_clear) begin
                    acc <= '0;
                end else begin
                    case (s1_op)
                        OP_LOAD: acc <= p_acc;
                        OP_ADD:  acc <= acc + p_acc;
                        OP_SUB:  acc <= acc - p_acc;
                        default: acc <= acc;
                    endcase
                end
            end
        end
    end

    // ---------------------------------------------------------------- stage 3
    logic signed [RW-1:0]    acc_ext;
    logic signed [RW-1:0]    r_sum;
    logic signed [RW-1:0]    r_shift;
    logic [M_DATA_BITS-1:0]  m_data_nxt;
    logic                    m_sat_nxt;

    assign acc_ext = RW'(acc);
    assign r_sum   = acc_ext + R_RND;
    assign r_shift = r_sum >>> DATA_SHIFT;

    // Round/shift result, optionally clamped to the output range
    always_comb begin
        m_data_nxt = r_shift[M_DATA_BITS-1:0];
        m_sat_nxt  = 1'b0;
        if (SATURATE) begin
            if (r_shift > R_MAX) begin
                m_data_nxt = R_MAX[M_DATA_BITS-1:0];
                m_sat_nxt  = 1'b1;
            end else if (r_shift < R_MIN) begin
                m_data_nxt = R_MIN[M_DATA_BITS-1:0];
                m_sat_nxt  = 1'b1;
            end
        end
    end

    logic [M_DATA_BITS-1:0] s3_data;
    logic                   s3_sat;
    logic                   s3_valid;

    // Output register; holds its last result across invalid beats
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_data  <= '0;
            s3_sat   <= 1'b0;
            s3_valid <= 1'b0;
        end else if (cke) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                if (s2_clear) begin
                    s3_data <= CLEAR_DATA;
                    s3_sat  <= 1'b0;
                end else begin
                    s3_data <= m_data_nxt;
                    s3_sat  <= m_sat_nxt;
                end
            end
        end
    end

    // ---------------------------------------------------------------- extra latency
    elixirchip_es1_spu_delay_an #(
        .WIDTH (M_DATA_BITS + 2),
        .DEPTH (TAIL)
    ) u_tail (
        .clk     (clk),
        .reset_n (reset_n),
        .cke     (cke),
        .din     ({s3_valid, s3_sat, s3_data}),
        .dout    ({m_valid, m_sat, m_data})
    );

endmodule

// File: tb/tb_elixirchip_es1_spu_op_mac.sv
// tb/tb_elixirchip_es1_spu_op_mac.sv - self-checking bench for elixirchip_es1_spu_op_mac
module tb_elixirchip_es1_spu_op_mac;

    localparam int N = 5;
    // Per-instance configuration as seen by the reference model
    localparam int LAT  [N] = '{4, 4, 4, 4, 6};
    localparam int S0S  [N] = '{1, 0, 1, 1, 1};
    localparam int MB   [N] = '{16, 8, 16, 16, 16};
    localparam int SH   [N] = '{0, 0, 2, 2, 0};
    localparam int RND  [N] = '{0, 0, 1, 0, 0};
    localparam int SAT  [N] = '{0, 1, 0, 0, 0};
    localparam int CLR  [N] = '{'h1234, 0, 0, 0, 0};
    localparam int ACCB = 24;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cke = 1'b1;
    logic [7:0] s_data0 = '0;
    logic [7:0] s_data1 = '0;
    logic [1:0] s_op = '0;
    logic       s_clear = 1'b0;
    logic       s_valid = 1'b0;

    logic [15:0] md0, md2, md3, md4;
    logic [7:0]  md1;
    logic        ms0, ms1, ms2, ms3, ms4;
    logic        mv0, mv1, mv2, mv3, mv4;

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_mac #(.CLEAR_DATA(16'h1234)) u0 (
        .clk(clk), .reset_n(reset_n), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
        .s_op(s_op), .s_clear(s_clear), .s_valid(s_valid), .m_data(md0), .m_sat(ms0), .m_valid(mv0));
    elixirchip_es1_spu_op_mac #(.DATA0_SIGNED(0), .M_DATA_BITS(8), .SATURATE(1)) u1 (
        .clk(clk), .reset_n(reset_n), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
        .s_op(s_op), .s_clear(s_clear), .s_valid(s_valid), .m_data(md1), .m_sat(ms1), .m_valid(mv1));
    elixirchip_es1_spu_op_mac #(.DATA_SHIFT(2), .ROUND(1)) u2 (
        .clk(clk), .reset_n(reset_n), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
        .s_op(s_op), .s_clear(s_clear), .s_valid(s_valid), .m_data(md2), .m_sat(ms2), .m_valid(mv2));
    elixirchip_es1_spu_op_mac #(.DATA_SHIFT(2), .ROUND(0)) u3 (
        .clk(clk), .reset_n(reset_n), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
        .s_op(s_op), .s_clear(s_clear), .s_valid(s_valid), .m_data(md3), .m_sat(ms3), .m_valid(mv3));
    elixirchip_es1_spu_op_mac #(.LATENCY(6)) u4 (
        .clk(clk), .reset_n(reset_n), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
        .s_op(s_op), .s_clear(s_clear), .s_valid(s_valid), .m_data(md4), .m_sat(ms4), .m_valid(mv4));

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    bit adv = 1'b0;

    typedef struct {
        int     inst;
        longint d;
        bit     s;
        int     cyc;
    } ent_t;
    ent_t lg[$];

    function automatic logic [17:0] dut_out(input int i);
        case (i)
            0: return {mv0, ms0, md0};
            1: return {mv1, ms1, 8'h00, md1};
            2: return {mv2, ms2, md2};
            3: return {mv3, ms3, md3};
            4: return {mv4, ms4, md4};
            default: return '0;
        endcase
    endfunction

    function automatic longint wrap(input longint v, input int bits);
        return (v <<< (64 - bits)) >>> (64 - bits);
    endfunction

    function automatic longint opnd(input logic [7:0] d, input int sgn);
        return (sgn != 0) ? longint'($signed(d)) : longint'(d);
    endfunction

    // Reference model: per-beat arithmetic result plus a LATENCY-deep delay queue
    longint acc_m [N];
    longint hd [N];
    bit     hs [N];
    longint qd [N][8];
    bit     qs [N][8];
    bit     qv [N][8];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                acc_m[i] = 0; hd[i] = 0; hs[i] = 0;
                for (int k = 0; k < 8; k++) begin
                    qd[i][k] = 0; qs[i][k] = 0; qv[i][k] = 0;
                end
            end
        end else if (cke) begin
            for (int i = 0; i < N; i++) begin
                longint p, r, mx, mn, mask;
                p = opnd(s_data0, S0S[i]) * opnd(s_data1, 0);
                if (s_valid) begin
                    if (s_clear) begin
                        acc_m[i] = 0; hd[i] = CLR[i]; hs[i] = 0;
                    end else begin
                        case (s_op)
                            2'd0: acc_m[i] = wrap(p, ACCB);
                            2'd1: acc_m[i] = wrap(acc_m[i] + p, ACCB);
                            2'd2: acc_m[i] = wrap(acc_m[i] - p, ACCB);
                            default: ;
                        endcase
                        r = acc_m[i];
                        if (RND[i] != 0 && SH[i] > 0) r = r + (longint'(1) <<< (SH[i] - 1));
                        r = r >>> SH[i];
                        mx = (longint'(1) <<< (MB[i] - 1)) - 1;
                        mn = -mx - 1;
                        mask = (longint'(1) <<< MB[i]) - 1;
                        if (SAT[i] != 0 && r > mx) begin
                            hd[i] = mx & mask; hs[i] = 1;
                        end else if (SAT[i] != 0 && r < mn) begin
                            hd[i] = mn & mask; hs[i] = 1;
                        end else begin
                            hd[i] = r & mask; hs[i] = 0;
                        end
                    end
                end
                for (int k = 7; k > 0; k--) begin
                    qd[i][k] = qd[i][k-1]; qs[i][k] = qs[i][k-1]; qv[i][k] = qv[i][k-1];
                end
                qd[i][0] = hd[i]; qs[i][0] = hs[i]; qv[i][0] = s_valid;
            end
        end
    end

    always @(posedge clk) begin
        adv = reset_n && cke;
        if (adv) cyc++;
    end

    // Every-cycle comparison of all instances against the model, plus capture of valid results
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            logic [17:0] o;
            longint ed;
            ed = qd[i][LAT[i]-1];
            o = dut_out(i);
            n_assert++;
            if (o[15:0] != ed[15:0] || o[16] != qs[i][LAT[i]-1] || o[17] != qv[i][LAT[i]-1]) begin
                n_fail++;
                $display("FAIL cycle_u%0d t=%0t: got v=%0b s=%0b d=%0h, expected v=%0b s=%0b d=%0h",
                         i, $time, o[17], o[16], o[15:0], qv[i][LAT[i]-1], qs[i][LAT[i]-1], ed[15:0]);
            end
            if (adv && o[17]) lg.push_back('{i, longint'(o[15:0]), o[16], cyc});
        end
    end

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int log_find(input int inst, input int idx);
        int k = 0;
        foreach (lg[j]) begin
            if (lg[j].inst == inst) begin
                if (k == idx) return j;
                k++;
            end
        end
        return -1;
    endfunction

    function automatic int log_count(input int inst);
        int k = 0;
        foreach (lg[j]) if (lg[j].inst == inst) k++;
        return k;
    endfunction

    task automatic check_log(input int inst, input int idx, input longint ed, input bit es, input string nm);
        int j;
        j = log_find(inst, idx);
        if (j < 0) begin
            chk(1'b0, {nm, "_missing"}, -1, ed);
        end else begin
            chk(lg[j].d == ed, nm, lg[j].d, ed);
            chk(lg[j].s == es, {nm, "_sat"}, longint'(lg[j].s), longint'(es));
        end
    endtask

    task automatic beat(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic clr);
        @(negedge clk);
        s_op = op; s_data0 = a; s_data1 = b; s_clear = clr; s_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        s_valid = 1'b0; s_clear = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, j, j2;
        repeat (3) @(negedge clk);
        chk(md0 == 16'h0, "reset_data", longint'(md0), 0);
        chk(ms0 == 1'b0, "reset_sat", longint'(ms0), 0);
        chk(mv4 == 1'b0, "reset_valid", longint'(mv4), 0);
        reset_n = 1'b1;

        // 1: signed x unsigned load and latency
        lg.delete();
        beat(2'd0, 8'hFD, 8'd200, 1'b0);
        c0 = cyc;
        idle(8);
        check_log(0, 0, 'hFDA8, 1'b0, "t1_load");
        j = log_find(0, 0);
        if (j >= 0) chk(lg[j].cyc - c0 == 4, "t1_latency", lg[j].cyc - c0, 4);

        // 2: back-to-back accumulate, subtract, hold
        lg.delete();
        beat(2'd0, 8'd0, 8'd0, 1'b0);
        beat(2'd1, 8'd10, 8'd10, 1'b0);
        beat(2'd1, 8'd20, 8'd5, 1'b0);
        beat(2'd1, 8'd3, 8'd3, 1'b0);
        beat(2'd2, 8'd4, 8'd4, 1'b0);
        beat(2'd3, 8'd0, 8'd0, 1'b0);
        idle(8);
        check_log(0, 1, 100, 1'b0, "t2_add1");
        check_log(0, 2, 200, 1'b0, "t2_add2");
        check_log(0, 3, 209, 1'b0, "t2_add3");
        check_log(0, 4, 193, 1'b0, "t2_sub");
        check_log(0, 5, 193, 1'b0, "t2_hold");
        j = log_find(0, 1); j2 = log_find(0, 4);
        if (j >= 0 && j2 >= 0) chk(lg[j2].cyc - lg[j].cyc == 3, "t2_no_bubbles", lg[j2].cyc - lg[j].cyc, 3);

        // 3: saturation, unsigned operands, 8-bit output
        lg.delete();
        beat(2'd0, 8'd100, 8'd100, 1'b0);
        beat(2'd2, 8'd255, 8'd255, 1'b0);
        idle(8);
        check_log(1, 0, 'h7F, 1'b1, "t3_sat_max");
        check_log(1, 1, 'h80, 1'b1, "t3_sat_min");

        // 4: shift with and without rounding
        lg.delete();
        beat(2'd0, 8'd2, 8'd3, 1'b0);
        beat(2'd0, 8'hFE, 8'd3, 1'b0);
        idle(8);
        check_log(2, 0, 2, 1'b0, "t4_round_pos");
        check_log(2, 1, 'hFFFF, 1'b0, "t4_round_neg");
        check_log(3, 0, 1, 1'b0, "t4_trunc_pos");
        check_log(3, 1, 'hFFFE, 1'b0, "t4_trunc_neg");

        // 5: clear beat
        lg.delete();
        beat(2'd0, 8'd20, 8'd25, 1'b0);
        beat(2'd1, 8'd9, 8'd9, 1'b1);
        beat(2'd1, 8'd1, 8'd1, 1'b0);
        idle(8);
        check_log(0, 0, 500, 1'b0, "t5_acc");
        check_log(0, 1, 'h1234, 1'b0, "t5_clear");
        check_log(0, 2, 1, 1'b0, "t5_after_clear");

        // 6a: clock enable stall mid-stream
        lg.delete();
        beat(2'd0, 8'd1, 8'd1, 1'b0);
        beat(2'd1, 8'd2, 8'd2, 1'b0);
        beat(2'd1, 8'd3, 8'd3, 1'b0);
        cke = 1'b0;
        repeat (3) @(negedge clk);
        cke = 1'b1;
        beat(2'd1, 8'd4, 8'd4, 1'b0);
        idle(8);
        chk(log_count(0) == 4, "t6_cke_beats", log_count(0), 4);
        check_log(0, 0, 1, 1'b0, "t6_cke_b0");
        check_log(0, 1, 5, 1'b0, "t6_cke_b1");
        check_log(0, 2, 14, 1'b0, "t6_cke_b2");
        check_log(0, 3, 30, 1'b0, "t6_cke_b3");

        // 6b: asynchronous reset mid-accumulation
        beat(2'd0, 8'd5, 8'd5, 1'b0);
        beat(2'd1, 8'd5, 8'd5, 1'b0);
        idle(8);
        beat(2'd1, 8'd7, 8'd7, 1'b0);
        @(posedge clk);
        s_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk(md4 == 16'h0, "t6_rst_data", longint'(md4), 0);
        chk(ms4 == 1'b0, "t6_rst_sat", longint'(ms4), 0);
        chk(mv4 == 1'b0, "t6_rst_valid", longint'(mv4), 0);
        chk(md0 == 16'h0, "t6_rst_data_u0", longint'(md0), 0);
        #1 reset_n = 1'b1;
        lg.delete();
        beat(2'd1, 8'd2, 8'd2, 1'b0);
        c0 = cyc;
        idle(8);
        check_log(4, 0, 4, 1'b0, "t6_post_rst_u4");
        check_log(0, 0, 4, 1'b0, "t6_post_rst_u0");
        j = log_find(4, 0);
        if (j >= 0) chk(lg[j].cyc - c0 == 6, "t6_latency6", lg[j].cyc - c0, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/elixirchip_es1_spu_op_mac.md
Name: elixirchip_es1_spu_op_mac

Overview:
Pipelined multiply-accumulate SPU operator. It is the parametrised successor to the fixed signed×unsigned multiplier. Signedness is selectable per operand. It adds a wide internal accumulator with per-beat opcode (load / add / subtract / hold), rounding right shift, optional output saturation, and a saturation flag. It sits in the SPU datapath between operand routing and the writeback pipeline, and keeps the usual cke / s_clear / s_valid contract.

Parameters:
LATENCY, 4, total input-to-output latency in cycles; must be >= 4.
S_DATA0_BITS, 8, s_data0 width.
S_DATA1_BITS, 8, s_data1 width.
DATA0_SIGNED, 1, 1 = s_data0 is two's complement, 0 = unsigned.
DATA1_SIGNED, 0, 1 = s_data1 is two's complement, 0 = unsigned.
ACC_BITS, S_DATA0_BITS+S_DATA1_BITS+8, accumulator width (signed); must be >= S_DATA0_BITS+S_DATA1_BITS+1.
M_DATA_BITS, 16, m_data width (signed).
DATA_SHIFT, 0, arithmetic right shift applied from accumulator to output, 0..ACC_BITS-1.
ROUND, 0, 1 = round-half-up before shift (adds 2^(DATA_SHIFT-1)); ignored when DATA_SHIFT=0.
SATURATE, 0, 1 = clamp to M_DATA_BITS signed range; 0 = truncate (wrap).
CLEAR_DATA, 0, value loaded to m_data on a clear beat.
DEVICE / SIMULATION / DEBUG, "RTL" / "false" / "false", passed through unchanged.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active low
cke  in  1  clock enable; 0 freezes every register
s_data0  in  S_DATA0_BITS  operand 0
s_data1  in  S_DATA1_BITS  operand 1
s_op  in  2  0=LOAD (acc=p), 1=ADD (acc+=p), 2=SUB (acc-=p), 3=HOLD (acc unchanged)
s_clear  in  1  clear accumulator and output
s_valid  in  1  beat valid
m_data  out  M_DATA_BITS  result
m_sat  out  1  1 when this m_data was clamped
m_valid  out  1  result valid

Behaviour:
- Reset: while reset_n=0 every pipeline register, the accumulator, m_data, m_sat and m_valid are 0, independent of clk and cke. Release is taken on the next clk edge.
- Only cycles with cke=1 advance. Valid and all data move together; with cke=0 all registers hold.
- Stage 0 registers s_data0, s_data1, s_op, s_clear and s_valid.
- Stage 1 computes the product p:
  - each operand is extended to S_DATA0_BITS+S_DATA1_BITS+1 bits, sign- or zero-extended per DATAn_SIGNED;
  - p is the exact signed product;
  - valid, op and clear are forwarded.
- Stage 2 updates the accumulator, only when valid:
  - clear=1: acc=0; clear overrides op.
  - otherwise acc follows op, computed modulo 2^ACC_BITS (wraps, no saturation inside the accumulator).
  - p is sign-extended to ACC_BITS before use.
  - The feedback path is single-cycle, so back-to-back ADD beats accumulate with no bubbles.
  - Invalid beats leave acc unchanged.
- Stage 3 produces the output, only when valid:
  - clear=1: m_data=CLEAR_DATA, m_sat=0.
  - otherwise r = (acc + (ROUND ? 2^(DATA_SHIFT-1) : 0)) >>> DATA_SHIFT, computed in ACC_BITS+1 bits so rounding cannot overflow.
  - SATURATE=1: r above 2^(M_DATA_BITS-1)-1 gives the maximum and m_sat=1; r below -2^(M_DATA_BITS-1) gives the minimum and m_sat=1; otherwise truncate with m_sat=0.
  - SATURATE=0: truncate, m_sat=0.
  - Invalid beats hold m_data and m_sat.
- Extra latency: LATENCY-4 further register stages on {m_data, m_sat, m_valid}. These use the same reset and cke and apply no data gating.
- Total latency is exactly LATENCY cke-enabled cycles. m_valid is s_valid delayed by LATENCY.
- A HOLD beat outputs the current acc (read-out without modification).
- Reset mid-accumulation discards acc. The first beat after reset with op=ADD accumulates onto 0.
- Elaboration error ($error) if LATENCY<4 or ACC_BITS is below its minimum.

Decomposition:
- Package elixirchip_es1_spu_pkg:
  - op_t enum (OP_LOAD, OP_ADD, OP_SUB, OP_HOLD);
  - a function computing signed min/max for a given width.
- One sub-module: elixirchip_es1_spu_delay_an. It is a parametrised async-active-low-reset, cke-gated delay line (WIDTH, DEPTH; DEPTH=0 is a wire) and provides the LATENCY-4 tail.

Test Plan:
1. DATA0_SIGNED=1, DATA1_SIGNED=0, LOAD, s_data0=8'hFD (-3), s_data1=200 -> 4 cycles later m_data=16'hFDA8 (-600), m_sat=0, m_valid=1.
2. Back-to-back ADD beats 10×10, 20×5, 3×3, then SUB 4×4 -> successive m_data 100, 200, 209, 193 on consecutive cycles; then HOLD -> 193.
3. SATURATE=1, M_DATA_BITS=8, both unsigned, LOAD 100×100 -> m_data=127, m_sat=1; then SUB 255×255 from 10000 -> m_data=-128, m_sat=1.
4. DATA_SHIFT=2, ROUND=1, LOAD 2×3 -> m_data=2; LOAD -2×3 -> m_data=-1; ROUND=0 with the same inputs -> 1 and -2.
5. Accumulate to 500, beat with s_clear=1 and CLEAR_DATA=16'h1234 -> m_data=16'h1234; next ADD 1×1 -> m_data=1.
6. Two cases:
   - cke=0 for 3 cycles mid-stream -> outputs frozen, results arrive late with no beat lost or duplicated.
   - reset_n pulsed low asynchronously mid-accumulation (LATENCY=6) -> m_data, m_sat, m_valid go to 0 immediately; next ADD 2×2 -> 4.
